// File: rtl/spi_mstr16_if.sv
// Bundles the spi_mstr16 host handshake and the four-wire SPI link.
// The master modport is the SPI master's view; slave is the opposite side.
interface spi_mstr16_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  wrt, cmd, MISO,
    output done, rd_data, SS_n, SCLK, MOSI
  );

  modport slave (
    output wrt, cmd, MISO,
    input  done, rd_data, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_mstr16.sv
// 16-bit SPI master: SCLK idles high, MISO is sampled on SCLK rise, and data is
// shifted on the following SCLK fall. done is sticky until the next accepted wrt.
module spi_mstr16 #(
  parameter int DIV_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  spi_mstr16_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, BACK_PORCH} state_t;

  localparam logic [DIV_W-1:0] DIV_HALF     = {1'b1, {(DIV_W-1){1'b0}}};
  localparam logic [DIV_W-1:0] DIV_PRE_RISE = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_LAST     = {DIV_W{1'b1}};

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg;
  logic [4:0]       bit_cnt_reg;
  logic [15:0]      shft_reg;
  logic             smpl_reg;
  logic             ss_n_reg;
  logic             done_reg;

  logic load, smpl_en, shft_en, finish;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (bus.wrt) state_next = SHIFT;
      SHIFT:      if (div_reg == DIV_PRE_RISE && bit_cnt_reg == 5'd15) state_next = BACK_PORCH;
      BACK_PORCH: if (div_reg == DIV_LAST) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // The first SCLK fall (bit_cnt still 0) is the front porch and shifts nothing.
  always_comb begin
    load    = 1'b0;
    smpl_en = 1'b0;
    shft_en = 1'b0;
    finish  = 1'b0;
    case (state_reg)
      IDLE:  load = bus.wrt;
      SHIFT: begin
        smpl_en = (div_reg == DIV_PRE_RISE);
        shft_en = (div_reg == DIV_LAST) && (bit_cnt_reg != 5'd0);
      end
      BACK_PORCH: begin
        finish  = (div_reg == DIV_LAST);
        shft_en = (div_reg == DIV_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg     <= DIV_HALF;
      bit_cnt_reg <= 5'd0;
      shft_reg    <= 16'h0000;
      smpl_reg    <= 1'b0;
      ss_n_reg    <= 1'b1;
      done_reg    <= 1'b0;
    end else if (load) begin
      div_reg     <= DIV_HALF;
      bit_cnt_reg <= 5'd0;
      shft_reg    <= bus.cmd;
      ss_n_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      // At the end of the back porch div reloads to HALF so SCLK never drops again.
      if (state_reg != IDLE) div_reg <= finish ? DIV_HALF : div_reg + 1'b1;
      if (smpl_en) begin
        smpl_reg    <= bus.MISO;
        bit_cnt_reg <= bit_cnt_reg + 5'd1;
      end
      if (shft_en) shft_reg <= {shft_reg[14:0], smpl_reg};
      if (finish) begin
        ss_n_reg <= 1'b1;
        done_reg <= 1'b1;
      end
    end
  end

  assign bus.SCLK    = div_reg[DIV_W-1];
  assign bus.SS_n    = ss_n_reg;
  assign bus.MOSI    = shft_reg[15];
  assign bus.done    = done_reg;
  assign bus.rd_data = shft_reg;

endmodule

// File: tb/tb_spi_mstr16.sv
// Self-checking bench for spi_mstr16 against an echo-style SPI slave that returns
// the previously completed command word (0xABCD before the first one).
module tb_spi_mstr16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_mstr16_if bus ();

  spi_mstr16 #(.DIV_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: loads its reply on SS_n fall, ignores the front-porch fall, samples on rise.
  logic [15:0] slv_tx = 16'h0000;
  logic [15:0] slv_rx = 16'h0000;
  logic [15:0] slv_resp = 16'hABCD;
  int slv_rises = 0;
  int slv_falls = 0;
  int done_pulses = 0;

  assign bus.MISO = slv_tx[15];

  always @(negedge bus.SS_n) begin
    slv_tx    = slv_resp;
    slv_rises = 0;
    slv_falls = 0;
  end
  always @(negedge bus.SCLK) if (!bus.SS_n) begin
    slv_falls++;
    if (slv_falls > 1) slv_tx = {slv_tx[14:0], 1'b0};
  end
  always @(posedge bus.SCLK) if (!bus.SS_n) begin
    slv_rx = {slv_rx[14:0], bus.MOSI};
    slv_rises++;
  end
  always @(posedge bus.SS_n) if (slv_rises == 16) slv_resp = slv_rx;
  always @(posedge bus.done) done_pulses++;

  // Reference model: each completed transfer returns the last completed cmd.
  logic [15:0] model_resp = 16'hABCD;
  int compared = 0;
  int mismatched = 0;
  int e0 = 0;
  int lat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns #1 after the accepting edge.
  task automatic start(input logic [15:0] c);
    bus.wrt = 1'b1;
    bus.cmd = c;
    done_pulses = 0;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.wrt = 1'b0;
    bus.cmd = 16'($urandom);
  endtask

  task automatic to_edge(input int n);
    do @(negedge clk); while (cyc < e0 + n - 1);
  endtask

  task automatic finish_txn(input logic [15:0] c, input string tag);
    lat = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = cyc - e0;
        break;
      end
    end
    check({tag, " latency"}, lat, 528);
    check({tag, " rd_data"}, bus.rd_data, model_resp);
    check({tag, " slave_rx"}, slv_rx, c);
    check({tag, " rises"}, slv_rises, 16);
    check({tag, " falls"}, slv_falls, 16);
    check({tag, " done_pulses"}, done_pulses, 1);
    check({tag, " ss_n_idle"}, bus.SS_n, 1'b1);
    check({tag, " sclk_idle"}, bus.SCLK, 1'b1);
    $display("txn %s cmd=%04h rd_data=%04h latency=%0d", tag, c, bus.rd_data, lat);
    model_resp = c;
  endtask

  initial begin
    logic [15:0] c;
    bus.wrt = 1'b0;
    bus.cmd = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst SS_n", bus.SS_n, 1'b1);
    check("rst SCLK", bus.SCLK, 1'b1);
    check("rst MOSI", bus.MOSI, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst rd_data", bus.rd_data, 16'h0000);

    @(negedge clk);
    start(16'h1234);
    check("first SS_n low", bus.SS_n, 1'b0);
    check("first MOSI msb", bus.MOSI, 1'b0);
    finish_txn(16'h1234, "first");

    repeat (3) @(negedge clk);
    start(16'h5A5A);
    finish_txn(16'h5A5A, "second");

    repeat (2) @(negedge clk);
    start(16'h00F0);
    to_edge(200);
    bus.wrt = 1'b1;
    bus.cmd = 16'hFFFF;
    @(negedge clk);
    bus.wrt = 1'b0;
    finish_txn(16'h00F0, "busy_wrt");

    // Back-to-back: accept wrt in the first cycle done is high.
    check("b2b done_high", bus.done, 1'b1);
    start(16'h8001);
    check("b2b done_clr", bus.done, 1'b0);
    check("b2b SS_n", bus.SS_n, 1'b0);
    finish_txn(16'h8001, "b2b");

    repeat (2) @(negedge clk);
    start(16'h3C3C);
    to_edge(300);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst SS_n", bus.SS_n, 1'b1);
    check("midrst SCLK", bus.SCLK, 1'b1);
    check("midrst done", bus.done, 1'b0);
    check("midrst rd_data", bus.rd_data, 16'h0000);
    repeat (40) @(negedge clk);
    check("midrst SCLK_quiet", bus.SCLK, 1'b1);
    $display("txn midrst cmd=3c3c aborted at edge 300");
    start(16'h0F0F);
    finish_txn(16'h0F0F, "after_rst");

    for (int k = 0; k < 4; k++) begin
      c = 16'($urandom);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      start(c);
      finish_txn(c, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
